// File: rtl/freqmeter_pkg.sv
// ----------------------------------------------------------------------------
// freqmeter_pkg
// Shared definitions for the frequency meter:
//   - gate window state encoding
//   - one-hot bit positions of the range select clk_wait[6:0]
//   - default gate lengths / period counts / hold and timeout limits
//   - counter widths and small select-decoding helpers
// ----------------------------------------------------------------------------
package freqmeter_pkg;

  // Gate window generator states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ARM   = 3'd2,
    ST_GATE  = 3'd3,
    ST_LATCH = 3'd4,
    ST_HOLD  = 3'd5
  } gw_state_e;

  // Range select width and one-hot bit positions (shared with select generator)
  localparam int SEL_W      = 7;
  localparam int SEL_F1MS   = 0;  // frequency mode, 1 ms gate
  localparam int SEL_F10MS  = 1;  // frequency mode, 10 ms gate
  localparam int SEL_F100MS = 2;  // frequency mode, 100 ms gate
  localparam int SEL_F1S    = 3;  // frequency mode, 1 s gate
  localparam int SEL_P1     = 4;  // period mode, 1 period
  localparam int SEL_P10    = 5;  // period mode, 10 periods
  localparam int SEL_P100   = 6;  // period mode, 100 periods

  // Default timing constants (CLK_50 cycles / signal periods)
  localparam int GATE0_DEF    = 50_000;
  localparam int GATE1_DEF    = 500_000;
  localparam int GATE2_DEF    = 5_000_000;
  localparam int GATE3_DEF    = 50_000_000;
  localparam int PER4_DEF     = 1;
  localparam int PER5_DEF     = 10;
  localparam int PER6_DEF     = 100;
  localparam int HOLD_CYC_DEF = 25_000_000;
  localparam int TIMEOUT_DEF  = 100_000_000;

  // Counter widths: cycle counter covers GATE3 and HOLD_CYC, edge counter
  // covers 100 periods, timeout counter covers TIMEOUT.
  localparam int CYC_CNT_W  = 26;
  localparam int EDGE_CNT_W = 7;
  localparam int TO_CNT_W   = 27;

  // True when exactly one select bit is set
  function automatic logic sel_is_onehot(input logic [SEL_W-1:0] sel);
    return (sel != 7'd0) && ((sel & (sel - 7'd1)) == 7'd0);
  endfunction

  // True when the select addresses a period-mode range
  function automatic logic sel_is_period(input logic [SEL_W-1:0] sel);
    return sel[SEL_P1] | sel[SEL_P10] | sel[SEL_P100];
  endfunction

endpackage

// File: rtl/sig_sync_edge.sv
// ----------------------------------------------------------------------------
// sig_sync_edge
// Two-flop synchronizer for an asynchronous input followed by a registered
// copy of the synchronized level; edge_o pulses for one cycle on each
// synchronized rising edge (sync=1, prev=0).
// Ports:
//   clk_i  : clock
//   rst_ni : synchronous active-low reset, clears all three flops
//   d_i    : asynchronous input
//   edge_o : one-cycle rising-edge pulse, two cycles after d_i rises
// ----------------------------------------------------------------------------
module sig_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic edge_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus previous-level register for edge detection
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign edge_o = sync_q & ~prev_q;

endmodule

// File: rtl/gate_window_gen.sv
// ----------------------------------------------------------------------------
// gate_window_gen
// Measurement-window generator for the frequency meter. Turns the one-hot
// range select into a counter gate window plus clear / latch strobes, a hold
// interval and fault flags.
//   Frequency mode (clk_wait[3:0]): gate open for GATEn CLK_50 cycles.
//   Period mode    (clk_wait[6:4]): gate aligned to sig_in rising edges,
//                                   spanning PERn signal periods.
// Ports:
//   CLK_50   : system clock, rising edge
//   nRST     : synchronous active-low reset
//   clk_wait : one-hot range select
//   sig_in   : asynchronous measured signal
//   gate     : counter enable window
//   clr      : one-cycle counter clear strobe
//   latch    : one-cycle result capture strobe
//   timeout  : period window timed out (set with latch, cleared with clr)
//   busy     : high outside IDLE
//   sel_err  : clk_wait is not exactly one-hot
//   gate_sel : clk_wait captured at CLEAR, used for display scaling
// ----------------------------------------------------------------------------
module gate_window_gen
  import freqmeter_pkg::*;
#(
  parameter int GATE0    = GATE0_DEF,
  parameter int GATE1    = GATE1_DEF,
  parameter int GATE2    = GATE2_DEF,
  parameter int GATE3    = GATE3_DEF,
  parameter int PER4     = PER4_DEF,
  parameter int PER5     = PER5_DEF,
  parameter int PER6     = PER6_DEF,
  parameter int HOLD_CYC = HOLD_CYC_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             CLK_50,
  input  logic             nRST,
  input  logic [SEL_W-1:0] clk_wait,
  input  logic             sig_in,
  output logic             gate,
  output logic             clr,
  output logic             latch,
  output logic             timeout,
  output logic             busy,
  output logic             sel_err,
  output logic [SEL_W-1:0] gate_sel
);

  // Terminal counts: every counter stops on an equality with (limit - 1)
  localparam logic [CYC_CNT_W-1:0] HOLD_LAST = CYC_CNT_W'(HOLD_CYC - 1);
  localparam logic [TO_CNT_W-1:0]  TO_LAST   = TO_CNT_W'(TIMEOUT - 1);

  gw_state_e              state_q;
  logic [CYC_CNT_W-1:0]   cyc_cnt_q;
  logic [CYC_CNT_W-1:0]   len_q;
  logic [EDGE_CNT_W-1:0]  edge_cnt_q;
  logic [EDGE_CNT_W-1:0]  per_q;
  logic [TO_CNT_W-1:0]    to_cnt_q;
  logic                   gate_q;
  logic                   clr_q;
  logic                   latch_q;
  logic                   timeout_q;
  logic                   busy_q;
  logic                   sel_err_q;
  logic [SEL_W-1:0]       gate_sel_q;

  logic                   sig_edge_s;
  logic                   sel_onehot_d;
  logic [CYC_CNT_W-1:0]   sel_len_d;
  logic [EDGE_CNT_W-1:0]  sel_per_d;
  logic                   cyc_done_d;
  logic                   hold_done_d;
  logic                   edge_done_d;
  logic                   to_done_d;
  logic                   abort_d;

  sig_sync_edge u_sig_sync (
    .clk_i  (CLK_50),
    .rst_ni (nRST),
    .d_i    (sig_in),
    .edge_o (sig_edge_s)
  );

  // Decode the live select into a gate length or a period count
  always_comb begin
    sel_onehot_d = sel_is_onehot(clk_wait);
    sel_len_d    = 26'd0;
    sel_per_d    = 7'd0;
    case (1'b1)
      clk_wait[SEL_F1MS]:   sel_len_d = CYC_CNT_W'(GATE0);
      clk_wait[SEL_F10MS]:  sel_len_d = CYC_CNT_W'(GATE1);
      clk_wait[SEL_F100MS]: sel_len_d = CYC_CNT_W'(GATE2);
      clk_wait[SEL_F1S]:    sel_len_d = CYC_CNT_W'(GATE3);
      clk_wait[SEL_P1]:     sel_per_d = EDGE_CNT_W'(PER4);
      clk_wait[SEL_P10]:    sel_per_d = EDGE_CNT_W'(PER5);
      clk_wait[SEL_P100]:   sel_per_d = EDGE_CNT_W'(PER6);
      default: begin
        sel_len_d = 26'd0;
        sel_per_d = 7'd0;
      end
    endcase
  end

  // Terminal-count compares and the abort condition
  always_comb begin
    cyc_done_d  = (cyc_cnt_q == (len_q - 26'd1));
    hold_done_d = (cyc_cnt_q == HOLD_LAST);
    edge_done_d = (edge_cnt_q == (per_q - 7'd1));
    to_done_d   = (to_cnt_q == TO_LAST);
    abort_d     = (clk_wait != gate_sel_q);
  end

  // Window state machine with registered strobes and flags
  always_ff @(posedge CLK_50) begin
    if (!nRST) begin
      state_q    <= ST_IDLE;
      cyc_cnt_q  <= 26'd0;
      len_q      <= 26'd0;
      edge_cnt_q <= 7'd0;
      per_q      <= 7'd0;
      to_cnt_q   <= 27'd0;
      gate_q     <= 1'b0;
      clr_q      <= 1'b0;
      latch_q    <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      sel_err_q  <= 1'b0;
      gate_sel_q <= 7'd0;
    end else begin
      // Strobes default low; the select fault flag tracks clk_wait continuously
      clr_q     <= 1'b0;
      latch_q   <= 1'b0;
      sel_err_q <= ~sel_onehot_d;
      case (state_q)
        ST_IDLE: begin
          if (sel_onehot_d) begin
            // Capture the range on entry so gate_sel is stable from clr onward
            state_q    <= ST_CLEAR;
            clr_q      <= 1'b1;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b1;
            gate_sel_q <= clk_wait;
            len_q      <= sel_len_d;
            per_q      <= sel_per_d;
          end else begin
            busy_q <= 1'b0;
          end
        end

        ST_CLEAR: begin
          cyc_cnt_q  <= 26'd0;
          edge_cnt_q <= 7'd0;
          to_cnt_q   <= 27'd0;
          if (sel_is_period(gate_sel_q)) begin
            state_q <= ST_ARM;
          end else begin
            state_q <= ST_GATE;
            gate_q  <= 1'b1;
          end
        end

        ST_ARM: begin
          if (abort_d) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (to_done_d) begin
            state_q   <= ST_LATCH;
            latch_q   <= 1'b1;
            timeout_q <= 1'b1;
          end else if (sig_edge_s) begin
            state_q  <= ST_GATE;
            gate_q   <= 1'b1;
            to_cnt_q <= to_cnt_q + 27'd1;
          end else begin
            to_cnt_q <= to_cnt_q + 27'd1;
          end
        end

        ST_GATE: begin
          if (abort_d) begin
            state_q <= ST_IDLE;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (sel_is_period(gate_sel_q)) begin
            // The closing edge takes priority over a coincident timeout
            if (sig_edge_s && edge_done_d) begin
              state_q <= ST_LATCH;
              gate_q  <= 1'b0;
              latch_q <= 1'b1;
            end else if (to_done_d) begin
              state_q   <= ST_LATCH;
              gate_q    <= 1'b0;
              latch_q   <= 1'b1;
              timeout_q <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 27'd1;
              if (sig_edge_s) begin
                edge_cnt_q <= edge_cnt_q + 7'd1;
              end else begin
                edge_cnt_q <= edge_cnt_q;
              end
            end
          end else begin
            if (cyc_done_d) begin
              state_q <= ST_LATCH;
              gate_q  <= 1'b0;
              latch_q <= 1'b1;
            end else begin
              cyc_cnt_q <= cyc_cnt_q + 26'd1;
            end
          end
        end

        ST_LATCH: begin
          state_q   <= ST_HOLD;
          cyc_cnt_q <= 26'd0;
        end

        ST_HOLD: begin
          if (hold_done_d) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cyc_cnt_q <= cyc_cnt_q + 26'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          gate_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gate     = gate_q;
  assign clr      = clr_q;
  assign latch    = latch_q;
  assign timeout  = timeout_q;
  assign busy     = busy_q;
  assign sel_err  = sel_err_q;
  assign gate_sel = gate_sel_q;

endmodule
